// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 scan-code constants, key indices and decoder state encoding.
package ps2_pkg;

  localparam logic [7:0] SC_EXT       = 8'hE0;
  localparam logic [7:0] SC_BRK       = 8'hF0;
  localparam logic [7:0] SC_PAUSE_PFX = 8'hE1;

  // Extended codes for the arrows, base codes for the rest.
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_P     = 8'h4D;

  localparam logic [2:0] KEY_UP    = 3'd0;
  localparam logic [2:0] KEY_DOWN  = 3'd1;
  localparam logic [2:0] KEY_LEFT  = 3'd2;
  localparam logic [2:0] KEY_RIGHT = 3'd3;
  localparam logic [2:0] KEY_ENTER = 3'd4;
  localparam logic [2:0] KEY_ESC   = 3'd5;
  localparam logic [2:0] KEY_SPACE = 3'd6;
  localparam logic [2:0] KEY_P     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BRK);
  endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Combinational scan-code to key-index lookup; the ext flag selects the E0 code page.
module ps2_keymap
  import ps2_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic       hit,
  output logic [2:0] id
);

  always_comb begin
    hit = 1'b0;
    id  = 3'd0;
    if (ext) begin
      case (code)
        SC_UP:    begin hit = 1'b1; id = KEY_UP;    end
        SC_DOWN:  begin hit = 1'b1; id = KEY_DOWN;  end
        SC_LEFT:  begin hit = 1'b1; id = KEY_LEFT;  end
        SC_RIGHT: begin hit = 1'b1; id = KEY_RIGHT; end
        default:  begin hit = 1'b0; id = 3'd0;      end
      endcase
    end else begin
      // Base-page 75/72/6B/74 are keypad digits and deliberately fall to default.
      case (code)
        SC_ENTER: begin hit = 1'b1; id = KEY_ENTER; end
        SC_ESC:   begin hit = 1'b1; id = KEY_ESC;   end
        SC_SPACE: begin hit = 1'b1; id = KEY_SPACE; end
        SC_P:     begin hit = 1'b1; id = KEY_P;     end
        default:  begin hit = 1'b0; id = 3'd0;      end
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 set-2 make/break/extended byte sequences into held-key levels,
// one-cycle press/release strobes and a debug word for the 7-segment display.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2_500_000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        code_valid,
  input  logic [7:0]  code,
  output logic [7:0]  keys,
  output logic        key_evt,
  output logic [2:0]  key_id,
  output logic        key_make,
  output logic [15:0] dbg
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic          done;
  logic          ext_seq;
  logic          brk_seq;
  logic          pfx;
  logic          hit;
  logic [2:0]    hit_id;
  logic          do_make;
  logic          do_break;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (code_valid || (state == ST_IDLE) || (cnt == CNT_MAX))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  // done marks a byte that completes a sequence; pfx marks a byte that only extends one.
  always_comb begin
    next_state = state;
    done       = 1'b0;
    ext_seq    = 1'b0;
    brk_seq    = 1'b0;
    pfx        = 1'b0;
    if (code_valid) begin
      case (state)
        ST_IDLE: begin
          if (code == SC_EXT) begin
            next_state = ST_EXT;
            pfx        = 1'b1;
          end else if (code == SC_BRK) begin
            next_state = ST_BRK;
            pfx        = 1'b1;
          end else if (code != SC_PAUSE_PFX) begin
            done = 1'b1;
          end
        end
        ST_EXT: begin
          next_state = ST_IDLE;
          if (code == SC_BRK) begin
            next_state = ST_EXT_BRK;
            pfx        = 1'b1;
          end else if (code == SC_EXT) begin
            next_state = ST_EXT;
            pfx        = 1'b1;
          end else if (code != SC_PAUSE_PFX) begin
            done    = 1'b1;
            ext_seq = 1'b1;
          end
        end
        ST_BRK: begin
          next_state = ST_IDLE;
          if (!is_prefix(code) && (code != SC_PAUSE_PFX)) begin
            done    = 1'b1;
            brk_seq = 1'b1;
          end
        end
        ST_EXT_BRK: begin
          next_state = ST_IDLE;
          if (!is_prefix(code) && (code != SC_PAUSE_PFX)) begin
            done    = 1'b1;
            ext_seq = 1'b1;
            brk_seq = 1'b1;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end else if ((state != ST_IDLE) && (cnt == CNT_MAX)) begin
      next_state = ST_IDLE;
    end
  end

  ps2_keymap u_keymap (
    .ext  (ext_seq),
    .code (code),
    .hit  (hit),
    .id   (hit_id)
  );

  // Typematic repeats and breaks of unheld keys are filtered by the current level.
  assign do_make  = done && hit && !brk_seq && !keys[hit_id];
  assign do_break = done && hit &&  brk_seq &&  keys[hit_id];

  always_ff @(posedge clk) begin
    if (!clr) begin
      keys     <= '0;
      key_evt  <= 1'b0;
      key_id   <= 3'd0;
      key_make <= 1'b0;
      dbg      <= '0;
    end else begin
      key_evt <= do_make || do_break;
      if (do_make || do_break) begin
        keys[hit_id] <= do_make;
        key_id       <= hit_id;
        key_make     <= do_make;
      end
      if (code_valid) begin
        dbg[7:0] <= code;
        if (!pfx)
          dbg[15:8] <= ext_seq ? SC_EXT : (brk_seq ? SC_BRK : 8'h00);
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed test-plan sequences plus random byte streams.
module tb_ps2_key_decoder;

  localparam int TO = 16;

  typedef struct {
    int unsigned edge_no;
    logic [2:0]  id;
    logic        mk;
    logic [7:0]  keys;
  } evt_t;

  typedef struct {
    int unsigned edge_no;
    logic [15:0] val;
  } dbg_t;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        code_valid = 1'b0;
  logic [7:0]  code = 8'h00;
  logic [7:0]  keys;
  logic        key_evt;
  logic [2:0]  key_id;
  logic        key_make;
  logic [15:0] dbg;

  ps2_key_decoder #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .clr        (clr),
    .code_valid (code_valid),
    .code       (code),
    .keys       (keys),
    .key_evt    (key_evt),
    .key_id     (key_id),
    .key_make   (key_make),
    .dbg        (dbg)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_vec  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  evt_t        ev_q[$];
  dbg_t        dbg_q[$];
  logic [7:0]  pend[$];
  logic [7:0]  m_keys = 8'h00;
  logic [15:0] m_dbg  = 16'h0000;
  int unsigned last_edge = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Key table straight from the key map: extended arrows, base enter/esc/space/P.
  function automatic int key_index(input bit ext, input logic [7:0] b);
    logic [7:0] ext_tab[4]  = '{8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] base_tab[4] = '{8'h5A, 8'h76, 8'h29, 8'h4D};
    for (int i = 0; i < 4; i++) begin
      if (ext && b == ext_tab[i]) return i;
      if (!ext && b == base_tab[i]) return i + 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    pend.delete();
    m_keys = 8'h00;
    m_dbg  = 16'h0000;
  endtask

  task automatic model_byte(input logic [7:0] b, input int unsigned e);
    bit has_e0;
    bit has_f0;
    int idx;
    evt_t ev;
    dbg_t dv;
    if (pend.size() > 0 && (e - last_edge) > TO) pend.delete();
    last_edge = e;
    has_e0 = 1'b0;
    has_f0 = 1'b0;
    foreach (pend[i]) begin
      if (pend[i] == 8'hE0) has_e0 = 1'b1;
      if (pend[i] == 8'hF0) has_f0 = 1'b1;
    end
    if (b == 8'hE1 || ((b == 8'hE0 || b == 8'hF0) && has_f0)) begin
      pend.delete();
      m_dbg = {8'h00, b};
    end else if (b == 8'hE0 || b == 8'hF0) begin
      pend.push_back(b);
      m_dbg[7:0] = b;
    end else begin
      idx = key_index(has_e0, b);
      m_dbg = {(has_e0 ? 8'hE0 : (has_f0 ? 8'hF0 : 8'h00)), b};
      pend.delete();
      if (idx >= 0 && m_keys[idx] == has_f0) begin
        m_keys[idx] = !has_f0;
        ev.edge_no = e;
        ev.id      = idx[2:0];
        ev.mk      = !has_f0;
        ev.keys    = m_keys;
        ev_q.push_back(ev);
      end
    end
    dv.edge_no = e;
    dv.val     = m_dbg;
    dbg_q.push_back(dv);
  endtask

  // Caller is at a negedge; the byte is sampled at the next posedge.
  task automatic apply_stimulus(input logic [7:0] b);
    code_valid = 1'b1;
    code       = b;
    model_byte(b, cyc + 1);
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    model_reset();
  endtask

  always @(negedge clk) begin : monitor
    evt_t e;
    if (mon_en) begin
      if (dbg_q.size() > 0 && dbg_q[0].edge_no <= cyc) begin
        check_output("dbg", {16'h0, dbg}, {16'h0, dbg_q[0].val});
        void'(dbg_q.pop_front());
      end
      if (key_evt === 1'b1) begin
        if (ev_q.size() > 0 && ev_q[0].edge_no == cyc) begin
          e = ev_q.pop_front();
          check_output("evt_id", {29'h0, key_id}, {29'h0, e.id});
          check_output("evt_make", {31'h0, key_make}, {31'h0, e.mk});
          check_output("evt_keys", {24'h0, keys}, {24'h0, e.keys});
        end else begin
          check_output("unexpected_evt", {31'h0, key_evt}, 32'h0);
        end
      end else if (ev_q.size() > 0 && ev_q[0].edge_no <= cyc) begin
        check_output("missing_evt", {31'h0, key_evt}, 32'h1);
        void'(ev_q.pop_front());
      end
    end
  end

  logic [7:0] pool[11] = '{8'hE0, 8'hF0, 8'hE1, 8'h75, 8'h72, 8'h6B, 8'h74,
                           8'h5A, 8'h76, 8'h29, 8'h4D};

  initial begin
    int r;
    logic [7:0] b;

    // Reset held for two edges against a coincident valid byte.
    clr = 1'b0;
    code_valid = 1'b1;
    code = 8'h5A;
    repeat (2) @(negedge clk);
    check_output("rst_evt", {31'h0, key_evt}, 32'h0);
    check_output("rst_keys", {24'h0, keys}, 32'h0);
    check_output("rst_dbg", {16'h0, dbg}, 32'h0);
    check_output("rst_id", {29'h0, key_id}, 32'h0);
    check_output("rst_make", {31'h0, key_make}, 32'h0);
    clr = 1'b1;
    code_valid = 1'b0;
    model_reset();
    mon_en = 1'b1;
    idle(2);

    // Extended up press and release.
    apply_stimulus(8'hE0);
    apply_stimulus(8'h75);
    check_output("up_press_keys", {24'h0, keys}, {24'h0, m_keys});
    idle(2);
    apply_stimulus(8'hE0);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h75);
    check_output("up_release_keys", {24'h0, keys}, {24'h0, m_keys});
    idle(2);

    // Typematic enter.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(8'h5A);
      idle(1);
    end
    check_output("enter_held", {24'h0, keys}, 32'h10);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h5A);
    check_output("enter_released", {24'h0, keys}, 32'h00);
    idle(2);

    // Back-to-back right + space.
    apply_stimulus(8'hE0);
    apply_stimulus(8'h74);
    apply_stimulus(8'h29);
    idle(1);
    check_output("right_space", {24'h0, keys}, 32'h48);
    apply_stimulus(8'hE0);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h74);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h29);
    idle(2);

    // Expired prefix: 75 becomes an unmapped keypad code.
    apply_stimulus(8'hE0);
    idle(TO);
    apply_stimulus(8'h75);
    check_output("timeout_keys", {24'h0, keys}, 32'h00);
    idle(2);

    // Last cycle before expiry: the prefix still applies.
    apply_stimulus(8'hE0);
    idle(TO - 1);
    apply_stimulus(8'h75);
    check_output("edge_of_timeout", {24'h0, keys}, 32'h01);
    idle(2);

    // Keypad-8 break while up is held, then a dropped E1.
    apply_stimulus(8'hF0);
    apply_stimulus(8'h75);
    check_output("kp8_break_keys", {24'h0, keys}, 32'h01);
    apply_stimulus(8'hE1);
    apply_stimulus(8'h5A);
    check_output("after_e1_keys", {24'h0, keys}, 32'h11);
    idle(2);

    // Reset in the middle of a prefix discards it.
    apply_stimulus(8'hE0);
    apply_reset();
    apply_stimulus(8'h75);
    check_output("rst_mid_seq_keys", {24'h0, keys}, 32'h00);
    idle(2);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 11);
      if (r == 11) b = 8'($urandom);
      else b = pool[r];
      apply_stimulus(b);
      r = $urandom_range(0, 9);
      if (r < 5) idle(0);
      else if (r < 9) idle($urandom_range(1, 3));
      else idle($urandom_range(TO - 2, TO + 1));
    end
    idle(4);
    check_output("rand_final_keys", {24'h0, keys}, {24'h0, m_keys});
    check_output("evt_queue_drained", ev_q.size(), 32'h0);
    check_output("dbg_queue_drained", dbg_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
